// File: rtl/csa_pkg.sv
// Shared constants and helpers for the pipelined carry-select add/sub unit.
package csa_pkg;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

    localparam int unsigned CSA_WIDTH = 16;
    localparam int unsigned CSA_BLK_W = 4;

    // Widest datapath the saturation helper can describe.
    localparam int unsigned SAT_MAX_W = 64;

    // Saturation limit of width w: 0x80..0 when neg, else 0x7F..F (upper bits zero).
    function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned w, input logic neg);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
            if (i + 1 < w) begin
                v[i] = ~neg;
            end else if (i + 1 == w) begin
                v[i] = neg;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational carry-select slice: two ripple paths (cin=0 / cin=1) and a select mux.
module csa_block #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_s,
    output logic         o_cout
);

    logic [W:0]   w_c0;
    logic [W:0]   w_c1;
    logic [W-1:0] w_s0;
    logic [W-1:0] w_s1;

    always_comb begin
        w_c0    = '0;
        w_c1    = '0;
        w_s0    = '0;
        w_s1    = '0;
        w_c0[0] = 1'b0;
        w_c1[0] = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            w_s0[i]   = i_a[i] ^ i_b[i] ^ w_c0[i];
            w_c0[i+1] = (i_a[i] & i_b[i]) | (w_c0[i] & (i_a[i] ^ i_b[i]));
            w_s1[i]   = i_a[i] ^ i_b[i] ^ w_c1[i];
            w_c1[i+1] = (i_a[i] & i_b[i]) | (w_c1[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_s    = i_cin ? w_s1 : w_s0;
    assign o_cout = i_cin ? w_c1[W] : w_c0[W];

endmodule

// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select add/sub, one block resolved per stage, valid/ready with global stall.
// Optional macro CSA_SAT_EN: saturate the sum on signed overflow in the output stage.
module csa_addsub_pipe
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = CSA_WIDTH,
    parameter int unsigned BLK_W = CSA_BLK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NUM_BLK = WIDTH / BLK_W;

    if ((WIDTH % BLK_W) != 0) begin : g_bad_width
        $error("csa_addsub_pipe: WIDTH must be a multiple of BLK_W");
    end

    // Stage k holds full operands (skew), carry into block k, and sum bits resolved so far.
    logic             r_vld [NUM_BLK];
    logic [WIDTH-1:0] r_a   [NUM_BLK];
    logic [WIDTH-1:0] r_b   [NUM_BLK];
    logic             r_c   [NUM_BLK];
    logic [WIDTH-1:0] r_s   [NUM_BLK];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [BLK_W-1:0] w_bs    [NUM_BLK];
    logic             w_bc    [NUM_BLK];
    logic [WIDTH-1:0] w_snext [NUM_BLK];
    logic             w_adv;
    logic             w_sub;
    logic [WIDTH-1:0] w_full;
    logic             w_cmsb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    assign w_adv = !r_out_valid || out_ready;
    assign w_sub = (mode == MODE_SUB);

    for (genvar g = 0; g < NUM_BLK; g++) begin : g_blk
        csa_block #(
            .W(BLK_W)
        ) u_blk (
            .i_a   (r_a[g][g*BLK_W +: BLK_W]),
            .i_b   (r_b[g][g*BLK_W +: BLK_W]),
            .i_cin (r_c[g]),
            .o_s   (w_bs[g]),
            .o_cout(w_bc[g])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_BLK; k++) begin
            w_snext[k]                    = r_s[k];
            w_snext[k][k*BLK_W +: BLK_W] = w_bs[k];
        end
    end

    // Carry into the MSB recovered from its sum bit; overflow when it differs from carry out.
    assign w_full = w_snext[NUM_BLK-1];
    assign w_cmsb = r_a[NUM_BLK-1][WIDTH-1] ^ r_b[NUM_BLK-1][WIDTH-1] ^ w_full[WIDTH-1];
    assign w_ovf  = w_cmsb ^ w_bc[NUM_BLK-1];

`ifdef CSA_SAT_EN
    // Effective-B sign selects direction: both operands negative can only overflow downward.
    assign w_res = w_ovf ? WIDTH'(sat_limit(WIDTH, r_b[NUM_BLK-1][WIDTH-1])) : w_full;
`else
    assign w_res = w_full;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_BLK; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_c[k]   <= 1'b0;
                r_s[k]   <= '0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_a[0] <= a;
                r_b[0] <= b ^ {WIDTH{w_sub}};
                r_c[0] <= w_sub;
                r_s[0] <= '0;
            end
            for (int unsigned k = 1; k < NUM_BLK; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_a[k] <= r_a[k-1];
                    r_b[k] <= r_b[k-1];
                    r_c[k] <= w_bc[k-1];
                    r_s[k] <= w_snext[k-1];
                end
            end
            r_out_valid <= r_vld[NUM_BLK-1];
            if (r_vld[NUM_BLK-1]) begin
                r_sum  <= w_res;
                r_cout <= w_bc[NUM_BLK-1];
                r_ovf  <= w_ovf;
                r_zero <= (w_res == '0);
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Scoreboard bench for csa_addsub_pipe (WIDTH=16, BLK_W=4, latency 4).
module tb_csa_addsub_pipe;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
        int           acc;
        bit           chk;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         zero;

    exp_t         sb[$];
    exp_t         mon_e;
    int           checks = 0;
    int           fails  = 0;
    int           cyc    = 0;
    bit           head_seen  = 1'b0;
    bit           prev_stall = 1'b0;
    bit           rand_rdy   = 1'b0;
    logic [W-1:0] prev_sum   = '0;

    csa_addsub_pipe #(
        .WIDTH(16),
        .BLK_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic v,
                                input logic z, input bit chk);
        exp_t e;
        e.s = s; e.c = c; e.v = v; e.z = z; e.acc = 0; e.chk = chk;
        return e;
    endfunction

    // Reference: plain 17-bit arithmetic with sign-rule overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic m, input bit chk);
        logic [W:0]   f;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        if (m) begin
            f = {1'b0, x} + {1'b0, y};
            c = f[W];
            s = f[W-1:0];
            v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        end else begin
            f = {1'b0, x} - {1'b0, y};
            c = (x >= y);
            s = f[W-1:0];
            v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        end
`ifdef CSA_SAT_EN
        if (v) s = s[W-1] ? 16'h7FFF : 16'h8000;
`endif
        return mk(s, c, v, (s == '0), chk);
    endfunction

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                        input exp_t e);
        exp_t q;
        int   n;
        q = e;
        a = x; b = y; mode = m; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            q.acc = cyc + 1;
            sb.push_back(q);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_sum", 32'(sum), 32'(prev_sum));
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out: got sum 0x%0h with no beat outstanding at t=%0t",
                             sum, $time);
                end else begin
                    if (!head_seen && sb[0].chk)
                        check("latency", 32'(cyc - sb[0].acc), 32'd4);
                    head_seen = 1'b1;
                    if (out_ready) begin
                        mon_e = sb.pop_front();
                        check("sum", 32'(sum), 32'(mon_e.s));
                        check("c_out", 32'(c_out), 32'(mon_e.c));
                        check("overflow", 32'(overflow), 32'(mon_e.v));
                        check("zero", 32'(zero), 32'(mon_e.z));
                        head_seen = 1'b0;
                    end
                end
                prev_stall = !out_ready;
                prev_sum   = sum;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         m;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", 32'({c_out, overflow, zero}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed single beats, hand-computed expectations
`ifdef CSA_SAT_EN
        send(16'h7FFF, 16'h0001, 1'b1, mk(16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1)); wait_drain();
        send(16'h8000, 16'h0001, 1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1)); wait_drain();
        send(16'h8000, 16'h8000, 1'b1, mk(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1)); wait_drain();
`else
        send(16'h7FFF, 16'h0001, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1)); wait_drain();
        send(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1)); wait_drain();
        send(16'h8000, 16'h8000, 1'b1, mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1)); wait_drain();
`endif
        send(16'h0005, 16'h0007, 1'b0, mk(16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1)); wait_drain();
        send(16'hFFFF, 16'h0001, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1)); wait_drain();
        send(16'h1234, 16'h1234, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1)); wait_drain();

        // Back-to-back directed beats exercising inter-block carries
        send(16'h0FFF, 16'h0001, 1'b1, mk(16'h1000, 1'b0, 1'b0, 1'b0, 1'b1));
        send(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1));
        send(16'h00F0, 16'h0F10, 1'b1, mk(16'h1000, 1'b0, 1'b0, 1'b0, 1'b1));
        send(16'h1000, 16'h0001, 1'b0, mk(16'h0FFF, 1'b1, 1'b0, 1'b0, 1'b1));
        wait_drain();

        // Random stream under random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            m = 1'($urandom_range(0, 1));
            send(x, y, m, model(x, y, m, 1'b0));
        end
        rand_rdy = 1'b0;
        wait_drain();

        // Alternating mode at full rate
        for (int i = 0; i < 8; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            m = 1'(i % 2);
            send(x, y, m, model(x, y, m, 1'b1));
        end
        wait_drain();

        // Reset with beats in flight
        send(16'h0011, 16'h0022, 1'b1, mk(16'h0033, 1'b0, 1'b0, 1'b0, 1'b0));
        send(16'h0100, 16'h0001, 1'b0, mk(16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0));
        send(16'h4000, 16'h0004, 1'b1, mk(16'h4004, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1 check("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        sb.delete();
        head_seen  = 1'b0;
        prev_stall = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_flags", 32'({c_out, overflow, zero}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(16'h0102, 16'h0304, 1'b1, mk(16'h0406, 1'b0, 1'b0, 1'b0, 1'b1));
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
